// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the uart_rx_frame receiver: FSM state encoding, sample-tick
// positions inside a bit period, and configuration range-check macros.
`ifndef UART_RX_FRAME_PKG_SV
`define UART_RX_FRAME_PKG_SV

`define UART_RX_DATA_W_OK(dw)    ((dw) >= 5 && (dw) <= 9)
`define UART_RX_STOP_BITS_OK(sb) ((sb) == 1 || (sb) == 2)

package uart_rx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Three votes straddle the bit centre; the decision lands on the last one.
  function automatic int unsigned tick_lo(input int unsigned clks);
    return clks / 2 - 1;
  endfunction

  function automatic int unsigned tick_mid(input int unsigned clks);
    return clks / 2;
  endfunction

  function automatic int unsigned tick_hi(input int unsigned clks);
    return clks / 2 + 1;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`endif

// File: rtl/uart_rx_frame_sampler.sv
// Line front end: 2-flop rx synchroniser, free-running bit-period tick counter
// (re-phased on each start edge) and 3-sample majority vote at mid-bit.
module uart_rx_sampler
  import uart_rx_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic restart,
  output logic fall,
  output logic bit_strobe,
  output logic bit_value
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TickLo   = TW'(tick_lo(CLKS_PER_BIT));
  localparam logic [TW-1:0] TickMid  = TW'(tick_mid(CLKS_PER_BIT));
  localparam logic [TW-1:0] TickHi   = TW'(tick_hi(CLKS_PER_BIT));
  localparam logic [TW-1:0] TickLast = TW'(CLKS_PER_BIT - 1);

  logic          rx_meta_q, rs_q, rs_prev_q;
  logic          samp_lo_q, samp_mid_q;
  logic [TW-1:0] tick_q, tick_d;

  always_comb begin
    tick_d = tick_q + TW'(1);
    if (restart || tick_q == TickLast) tick_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rs_q       <= 1'b1;
      rs_prev_q  <= 1'b1;
      samp_lo_q  <= 1'b1;
      samp_mid_q <= 1'b1;
      tick_q     <= '0;
    end else begin
      rx_meta_q <= rx;
      rs_q      <= rx_meta_q;
      rs_prev_q <= rs_q;
      tick_q    <= tick_d;
      if (tick_q == TickLo)  samp_lo_q  <= rs_q;
      if (tick_q == TickMid) samp_mid_q <= rs_q;
    end
  end

  assign fall       = rs_prev_q & ~rs_q;
  assign bit_strobe = (tick_q == TickHi);
  assign bit_value  = maj3(samp_lo_q, samp_mid_q, rs_q);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with valid/ready output register and saturating error count.
// Define UART_PARITY_EN to add a parity bit between data and stop bits.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rx,
  output logic [DATA_W-1:0]    m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  if (!(`UART_RX_DATA_W_OK(DATA_W) && `UART_RX_STOP_BITS_OK(STOP_BITS) &&
        CLKS_PER_BIT >= 4 && CLKS_PER_BIT % 2 == 0 && (PARITY_ODD == 0 || PARITY_ODD == 1)))
  begin : g_bad_cfg
    $error("uart_rx_frame: illegal parameter combination");
  end

  localparam int CW = 4;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [DATA_W-1:0]      m_data_q, m_data_d;
  logic                   m_valid_q, m_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;
  logic                   overrun_q, overrun_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                   restart, deliver;
  logic                   fall, bit_strobe, bit_value;

  uart_rx_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .restart    (restart),
    .fall       (fall),
    .bit_strobe (bit_strobe),
    .bit_value  (bit_value)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    restart      = 1'b0;
    deliver      = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (fall) begin
          state_d = ST_START;
          restart = 1'b1;
        end
        ST_START: if (bit_strobe) begin
          state_d = bit_value ? ST_IDLE : ST_DATA;
          cnt_d   = '0;
        end
        ST_DATA: if (bit_strobe) begin
          shift_d = {bit_value, shift_q[DATA_W-1:1]};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) begin
            cnt_d = '0;
`ifdef UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: if (bit_strobe) begin
          if (bit_value != ((^shift_q) ^ 1'(PARITY_ODD))) begin
            parity_err_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            state_d = ST_STOP;
          end
        end
`endif
        ST_STOP: if (bit_strobe) begin
          cnt_d = cnt_q + CW'(1);
          if (!bit_value) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end else if (cnt_q == CW'(STOP_BITS - 1)) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output register: an undrained word wins over a new one, which is dropped.
  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    overrun_d = 1'b0;
    if (deliver) begin
      if (m_valid_q && !m_ready) begin
        overrun_d = 1'b1;
      end else begin
        m_data_d  = shift_q;
        m_valid_d = 1'b1;
      end
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
    err_cnt_d = err_cnt_q;
    if ((frame_err_d || parity_err_d || overrun_d) && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame (C=16, DATA_W=8, one stop bit).
// Parity scenario runs only when UART_PARITY_EN is defined.
module tb_uart_rx_frame;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       rx = 1'b1;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_valid, busy, frame_err, parity_err, overrun;
  logic [7:0] err_cnt;

  int n_chk = 0;
  int n_fail = 0;

  // Observation counters (cycles each signal was seen high, accepted words)
  int         n_fe = 0, n_pe = 0, n_ov = 0, n_vcyc = 0, n_acc = 0;
  logic [7:0] last_word = 8'h00;

  uart_rx_frame dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rx         (rx),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err)  n_fe++;
    if (parity_err) n_pe++;
    if (overrun)    n_ov++;
    if (m_valid)    n_vcyc++;
    if (m_valid && m_ready) begin
      n_acc++;
      last_word = m_data;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    step(C);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
    send_bit(par);
`else
    if (par) rx = 1'b1;
`endif
    send_bit(stop_v);
    rx = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
  endtask

  int fe0, pe0, ov0, vc0, ac0;

  task automatic snap();
    fe0 = n_fe; pe0 = n_pe; ov0 = n_ov; vc0 = n_vcyc; ac0 = n_acc;
  endtask

  initial begin
    step(3);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    rst = 1'b0;
    step(4);

    // 1: single word 0xA5, consumer always ready
    snap();
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("t1_busy_after_stop", 32'(busy), 32'd0);
    step(2);
    chk("t1_word", 32'(last_word), 32'hA5);
    chk("t1_accepts", 32'(n_acc - ac0), 32'd1);
    chk("t1_valid_cycles", 32'(n_vcyc - vc0), 32'd1);
    chk("t1_err_pulses", 32'(n_fe - fe0 + n_pe - pe0 + n_ov - ov0), 32'd0);
    chk("t1_m_data", 32'(m_data), 32'hA5);

    // 2: back-to-back words with consumer stalled -> overrun on the second
    m_ready = 1'b0;
    snap();
    send_frame(8'h3C, 1'b1, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1);
    step(2);
    chk("t2_m_data_held", 32'(m_data), 32'h3C);
    chk("t2_m_valid", 32'(m_valid), 32'd1);
    chk("t2_overrun_cycles", 32'(n_ov - ov0), 32'd1);
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);
    m_ready = 1'b1;
    step(2);
    chk("t2_m_valid_drained", 32'(m_valid), 32'd0);
    chk("t2_consumed_word", 32'(last_word), 32'h3C);

    // 3: stop bit forced low, then a clean frame
    do_reset();
    snap();
    send_frame(8'h55, 1'b1, 1'b0);
    step(4);
    chk("t3_frame_err_cycles", 32'(n_fe - fe0), 32'd1);
    chk("t3_no_valid", 32'(n_vcyc - vc0), 32'd0);
    chk("t3_err_cnt", 32'(err_cnt), 32'd1);
    send_frame(8'h12, 1'b0, 1'b1);
    step(4);
    chk("t3_clean_word", 32'(last_word), 32'h12);
    chk("t3_clean_accepts", 32'(n_acc - ac0), 32'd1);

    // 4: 4-cycle low glitch while idle
    snap();
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(4);
    chk("t4_busy_in_start", 32'(busy), 32'd1);
    step(30);
    chk("t4_busy_back_idle", 32'(busy), 32'd0);
    chk("t4_no_flags", 32'(n_fe - fe0 + n_pe - pe0 + n_ov - ov0), 32'd0);
    chk("t4_no_valid", 32'(n_vcyc - vc0), 32'd0);

    // 5: reset pulse in the middle of data bit 3
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b0;
    step(8);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t5_rst_m_data", 32'(m_data), 32'h00);
    chk("t5_rst_m_valid", 32'(m_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_err_cnt", 32'(err_cnt), 32'd0);
    rx = 1'b1;
    step(3 * C);
    snap();
    send_frame(8'h81, 1'b0, 1'b1);
    step(4);
    chk("t5_word", 32'(last_word), 32'h81);
    chk("t5_accepts", 32'(n_acc - ac0), 32'd1);

`ifdef UART_PARITY_EN
    // 6: even parity; 0x07 has three ones, so the correct parity bit is 1
    snap();
    send_frame(8'h07, 1'b0, 1'b1);
    step(4);
    chk("t6_parity_err_cycles", 32'(n_pe - pe0), 32'd1);
    chk("t6_no_valid", 32'(n_vcyc - vc0), 32'd0);
    send_frame(8'h07, 1'b1, 1'b1);
    step(4);
    chk("t6_good_word", 32'(last_word), 32'h07);
    chk("t6_good_accepts", 32'(n_acc - ac0), 32'd1);
`else
    chk("t6_parity_err_never", 32'(n_pe), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
Parametrised serial receiver, successor to the fixed 8-bit UART front end of the transceiver chain. It oversamples the asynchronous rx line and majority-votes each bit. It assembles DATA_W-bit words LSB first and checks stop bits (and parity when compiled in). Each accepted word is presented on a valid/ready output register with error flags and a saturating error counter; downstream is the encoder stage.

Parameters:
DATA_W, 8, data bits per frame; legal 5..9
CLKS_PER_BIT, 16, clk cycles per bit; even, >=4
STOP_BITS, 1, stop bits checked; 1 or 2
PARITY_ODD, 0, 0 = even parity, 1 = odd; used only with UART_PARITY_EN
ERR_CNT_W, 8, width of error counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active high
en  in  1  receiver enable
rx  in  1  asynchronous serial line, idle high
m_data  out  DATA_W  received word
m_valid  out  1  m_data holds an unconsumed word
m_ready  in  1  consumer accepts word when m_valid&&m_ready
busy  out  1  FSM not in IDLE
frame_err  out  1  one-cycle pulse, stop bit sampled 0
parity_err  out  1  one-cycle pulse, parity mismatch
overrun  out  1  one-cycle pulse, good word dropped because m_valid still set
err_cnt  out  ERR_CNT_W  saturating count of frame_err+parity_err+overrun events

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: m_data=0, m_valid=0, busy=0, all error pulses 0, err_cnt=0. rx synchroniser flops reset to 1. FSM resets to IDLE, bit counter to 0.
- rx passes through a 2-flop synchroniser; all logic uses the synchronised value rs. Its falling edge is rs_d=1 && rs=0.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: on falling edge with en=1, go to START and clear the tick counter. Call this cycle t0.
- Tick counter counts 0..CLKS_PER_BIT-1 and wraps.
- Sample point: majority of rs at tick C/2-1, C/2 and C/2+1, where C=CLKS_PER_BIT. The decision is made at tick C/2+1.
- START: voted 1 means a glitch; return to IDLE with no flags. Voted 0 goes to DATA.
- DATA: shift the voted bit into the MSB of the shift register (LSB-first line order). After DATA_W bits, go to PARITY if compiled in, else STOP.
- STOP: sample STOP_BITS bits.
  - Any stop bit voted 0: frame_err pulse, word discarded, go to IDLE.
  - After the last good stop bit: deliver the word and go to IDLE immediately, so the next start edge is caught mid-stop.
- Delivery: m_data/m_valid are updated on the edge following the last stop decision.
  - If m_valid=1 && m_ready=0 in that cycle: keep old m_data, drop the new word, pulse overrun.
  - If m_valid && m_ready and a new word arrive in the same cycle: load the new word and keep m_valid=1.
- m_valid clears on m_valid&&m_ready with no new word arriving.
- m_data is stable while m_valid=1 && m_ready=0.
- err_cnt: +1 per cycle in which any error pulse is asserted (simultaneous flags count once). Saturates at all-ones.
- en=0: FSM returns to IDLE on the next edge and aborts any frame without flags. The output register and its handshake keep operating.
- busy = (state != IDLE).

Optional Feature:
UART_PARITY_EN defined:
- PARITY state follows DATA and samples one bit.
- Expected parity is XOR(data) ^ PARITY_ODD.
- On mismatch: parity_err pulse, word discarded, go to IDLE without checking stop bits.

UART_PARITY_EN undefined:
- No PARITY state.
- parity_err is tied 0.
- PARITY_ODD is ignored.

Decomposition:
- Shared package/include: state encoding constants (IDLE..STOP), the C/2 sample-tick constants, and STOP_BITS/DATA_W range-check macros.
- One natural sub-module: uart_rx_sampler. It holds the synchroniser, tick counter and 3-sample majority vote, and outputs bit_strobe and bit_value to the framing FSM.

Test Plan:
All scenarios use C=16 and DATA_W=8 unless noted.
1. Line sends 0xA5, 1 stop, m_ready=1 -> m_data=0xA5, m_valid high exactly 1 cycle, no error flags, busy drops after the stop decision.
2. Back-to-back 0x3C then 0xC3, m_ready=0 -> m_data stays 0x3C, one overrun pulse at the second delivery, err_cnt=1. Then m_ready=1 -> 0x3C consumed, m_valid=0.
3. 0x55 with stop bit forced 0 -> frame_err pulse, m_valid stays 0, err_cnt=1. The following clean 0x12 is received correctly.
4. rx low for 4 cycles while idle -> START rejects it as a glitch, busy returns to 0, no flags, no m_valid.
5. rst asserted 1 cycle during data bit 3 of a frame -> every output at its reset value next cycle. The next clean 0x81 is received correctly.
6. UART_PARITY_EN, PARITY_ODD=0, 0x07 sent with parity bit 0 -> parity_err pulse, no m_valid. The same frame with parity bit 1 -> m_data=0x07.
